// File: rtl/systolic_result_drainer.sv
// systolic_result_drainer
// Captures a packed M x P result matrix on a 'done' pulse and streams it out
// one element per handshake in row-major order.
//
// Handshake: a beat transfers on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, out_data/out_row/out_col/
// out_last hold stable. out_valid never drops until the beat is taken.
//
// Optional feature: define DRAIN_OVERRUN_CNT_EN to add an 8-bit saturating
// overrun_cnt output counting dropped 'done' pulses.
module systolic_result_drainer #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int P          = 8,
    localparam int RW        = (M > 1) ? $clog2(M) : 1,
    localparam int CW        = (P > 1) ? $clog2(P) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      done,
    input  logic [M*P*DATA_WIDTH-1:0] result_c,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RW-1:0]             out_row,
    output logic [CW-1:0]             out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      drain_done,
`ifdef DRAIN_OVERRUN_CNT_EN
    output logic                      overrun,
    output logic [7:0]                overrun_cnt
`else
    output logic                      overrun
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int NUM_ELEM = M * P;

    state_t                      state_q;
    logic [NUM_ELEM*DATA_WIDTH-1:0] buf_q;
    logic [RW-1:0]               row_q;
    logic [CW-1:0]               col_q;
    logic [DATA_WIDTH-1:0]       data_q;
    logic                        valid_q;
    logic                        last_q;
    logic                        busy_q;
    logic                        drain_done_q;
    logic                        overrun_q;

    logic                        at_last;
    logic                        final_xfer;
    logic                        capture;
    logic                        drop_done;
    logic [RW-1:0]               row_d;
    logic [CW-1:0]               col_d;
    logic                        last_d;
    logic [DATA_WIDTH-1:0]       data_d;
    int                          flat_d;

    // Next index, next element and the capture/drop decisions for this cycle.
    always_comb begin
        at_last    = (row_q == RW'(M - 1)) && (col_q == CW'(P - 1));
        final_xfer = (state_q == STREAM) && out_ready && at_last;
        capture    = done && ((state_q == IDLE) || final_xfer);
        drop_done  = done && (state_q == STREAM) && !final_xfer;
        row_d      = row_q;
        col_d      = col_q;
        if (col_q == CW'(P - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
        end else begin
            col_d = col_q + CW'(1);
        end
        last_d = (row_d == RW'(M - 1)) && (col_d == CW'(P - 1));
        flat_d = int'(row_d) * P + int'(col_d);
        // Past the final element the index wraps; keep the select in range.
        if (flat_d >= NUM_ELEM) begin
            flat_d = 0;
        end
        data_d = buf_q[flat_d*DATA_WIDTH +: DATA_WIDTH];
    end

    // Result buffer: contents are only observable while out_valid=1, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= result_c;
        end
    end

    // Drain FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            overrun_q    <= drop_done;
            case (state_q)
                IDLE: begin
                    if (done) begin
                        state_q <= STREAM;
                        row_q   <= '0;
                        col_q   <= '0;
                        data_q  <= result_c[DATA_WIDTH-1:0];
                        last_q  <= (NUM_ELEM == 1);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (final_xfer) begin
                        drain_done_q <= 1'b1;
                        row_q        <= '0;
                        col_q        <= '0;
                        if (done) begin
                            // Back-to-back capture on the final beat.
                            data_q  <= result_c[DATA_WIDTH-1:0];
                            last_q  <= (NUM_ELEM == 1);
                        end else begin
                            state_q <= IDLE;
                            data_q  <= '0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else if (out_ready) begin
                        row_q  <= row_d;
                        col_q  <= col_d;
                        data_q <= data_d;
                        last_q <= last_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DRAIN_OVERRUN_CNT_EN
    // Saturating count of dropped 'done' pulses, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_cnt <= 8'd0;
        end else if (drop_done && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_last   = last_q;
    assign busy       = busy_q;
    assign drain_done = drain_done_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/systolic_result_drainer.md
SYSTOLIC_RESULT_DRAINER -- requirements
Module: systolic_result_drainer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bit width of one result element.
REQ-002 SHALL have parameter M, default 8: number of result rows.
REQ-003 SHALL have parameter P, default 8: number of result columns.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port done  input  1  completion pulse from the multiplier.
REQ-007 SHALL have port result_c  input  M*P*DATA_WIDTH  packed result; element (i,j) at bits [(i*P+j)*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port out_data  output  DATA_WIDTH  current streamed element.
REQ-009 SHALL have port out_valid  output  1  out_data/out_row/out_col/out_last valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts when high with out_valid.
REQ-011 SHALL have port out_row  output  clog2(M) (min 1)  row index of out_data.
REQ-012 SHALL have port out_col  output  clog2(P) (min 1)  column index of out_data.
REQ-013 SHALL have port out_last  output  1  high with element (M-1,P-1).
REQ-014 SHALL have port busy  output  1  high while in STREAM.
REQ-015 SHALL have port drain_done  output  1  one-cycle pulse after final handshake.
REQ-016 SHALL have port overrun  output  1  one-cycle pulse when done arrives and is dropped.

Function
REQ-017 SHALL implement two states: IDLE and STREAM.
REQ-018 In IDLE, done=1 at an edge SHALL latch all of result_c into an internal buffer, reset the index to (0,0), and enter STREAM.
REQ-019 out_valid SHALL be high in every STREAM cycle and low in IDLE; first out_valid occurs one cycle after the capturing edge.
REQ-020 Element order SHALL be row-major: (0,0),(0,1)..(0,P-1),(1,0)..(M-1,P-1); out_data taken from the latched buffer, never live result_c.
REQ-021 A transfer SHALL occur only when out_valid=1 and out_ready=1; the index then advances one element.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-023 Transfer of element (M-1,P-1) SHALL return the FSM to IDLE and assert drain_done for exactly the next cycle.
REQ-024 done=1 in STREAM, except on the final-transfer cycle, SHALL be dropped and SHALL pulse overrun the next cycle; the buffer is not modified.
REQ-025 done=1 coincident with the final transfer SHALL be captured: next cycle stays STREAM at index (0,0) with the new data, drain_done still pulses, no overrun.
REQ-026 With out_ready held high, an M*P-element drain SHALL take exactly M*P cycles with no bubbles.
REQ-027 busy SHALL equal (state == STREAM).

Reset
REQ-028 rst=0 SHALL immediately, without a clock edge, force IDLE, index (0,0), and out_valid, out_last, busy, drain_done, overrun to 0; out_data, out_row, out_col to 0.
REQ-029 Reset mid-stream SHALL abandon the drain; no drain_done is issued for it.
REQ-030 Buffer contents need not be reset; they SHALL never be visible while out_valid=0.

Configuration
REQ-031 With macro DRAIN_OVERRUN_CNT_EN defined, the block SHALL add output overrun_cnt (8 bits), incremented on each overrun pulse, saturating at 255, cleared only by reset.
REQ-032 Without DRAIN_OVERRUN_CNT_EN, port overrun_cnt and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset release, done pulse, result_c element k = k (0..63), out_ready=1 -> 64 consecutive beats with data 0..63, out_last only on beat 63, drain_done one cycle later.
REQ-034 Same load, out_ready toggled 1,0,1,0 -> data 0..63 in order, each beat held stable while stalled, drain takes 128 cycles.
REQ-035 result_c changed to all 0xFF one cycle after capture -> streamed data still 0..63.
REQ-036 done pulsed at beat 10 -> overrun pulse, stream continues 11..63 unchanged; overrun_cnt = 1 when DRAIN_OVERRUN_CNT_EN is defined.
REQ-037 done coincident with final handshake, new data all 0x5A -> next cycle out_valid=1, out_row=0, out_col=0, data 0x5A; drain_done pulses, no overrun.
REQ-038 rst asserted at beat 20 -> out_valid and busy low immediately; no drain_done; next done restarts at (0,0).
